// File: rtl/lk_accum.sv
// lk_accum: walks a linked list held in an external synchronous memory
// (value at p, next pointer at p+1, pointer 0 terminates) and reduces the
// node values with sum, unsigned max, node count or xor.
module lk_accum #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 8,
   parameter int MAX_NODES = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] head,
   input  logic [1:0]        mode,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] result,
   output logic [ADDR_W:0]   nodes,
   output logic              busy,
   output logic              done,
   output logic              ovf,
   output logic              loop_err,
   output logic [1:0]        status
);

   typedef enum logic [2:0] {IDLE, VAL, NXT, DONE, ERR} state_t;

   localparam logic [1:0] MODE_SUM = 2'd0;
   localparam logic [1:0] MODE_MAX = 2'd1;
   localparam logic [1:0] MODE_CNT = 2'd2;
   localparam logic [1:0] MODE_XOR = 2'd3;

   state_t            state, state_next;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] issue_addr;
   logic [ADDR_W-1:0] nxt_ptr;
   logic [1:0]        mode_q;
   logic [DATA_W:0]   sum_ext;
   logic [ADDR_W:0]   cnt_inc;
   logic              accept;
   logic              at_limit;

   assign accept   = rst_n && start && (state == IDLE || state == DONE || state == ERR);
   assign nxt_ptr  = mem_rdata[ADDR_W-1:0];
   assign cnt_inc  = nodes + 1'b1;
   assign at_limit = (cnt_inc == (ADDR_W+1)'(MAX_NODES));
   assign sum_ext  = {1'b0, result} + {1'b0, mem_rdata};
   assign mem_addr = issue_addr;

   // State register; reset abandons any walk in progress at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and read issue: reads are combinational so the synchronous
   // memory returns the word in the very next cycle, giving two cycles per node.
   always_comb begin
      state_next = state;
      mem_rd     = 1'b0;
      issue_addr = addr_q;
      case (state)
         IDLE, DONE, ERR: begin
            if (accept) begin
               if (head == '0) begin
                  state_next = DONE;
               end else begin
                  mem_rd     = 1'b1;
                  issue_addr = head;
                  state_next = VAL;
               end
            end
         end
         VAL: begin
            mem_rd     = 1'b1;
            issue_addr = ptr + 1'b1;
            state_next = NXT;
         end
         NXT: begin
            if (nxt_ptr == '0) begin
               state_next = DONE;
            end else if (at_limit) begin
               state_next = ERR;
            end else begin
               mem_rd     = 1'b1;
               issue_addr = nxt_ptr;
               state_next = VAL;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Remember the last issued address so mem_addr holds between reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
      end else begin
         addr_q <= issue_addr;
      end
   end

   // Datapath: clear on an accepted start, fold values in VAL, count in NXT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result <= '0;
         nodes  <= '0;
         ovf    <= 1'b0;
         mode_q <= MODE_SUM;
         ptr    <= '0;
      end else if (accept) begin
         result <= '0;
         nodes  <= '0;
         ovf    <= 1'b0;
         mode_q <= mode;
         ptr    <= head;
      end else if (state == VAL) begin
         case (mode_q)
            MODE_SUM: begin
               result <= sum_ext[DATA_W-1:0];
               if (sum_ext[DATA_W]) begin
                  ovf <= 1'b1;
               end
            end
            MODE_MAX: begin
               if (mem_rdata > result) begin
                  result <= mem_rdata;
               end
            end
            MODE_XOR: result <= result ^ mem_rdata;
            default:  result <= result;
         endcase
      end else if (state == NXT) begin
         nodes <= cnt_inc;
         if (mode_q == MODE_CNT) begin
            result <= DATA_W'(cnt_inc);
         end
         if (state_next == VAL) begin
            ptr <= nxt_ptr;
         end
      end
   end

   // Status flags decode directly from the state.
   always_comb begin
      busy     = (state == VAL) || (state == NXT);
      done     = (state == DONE);
      loop_err = (state == ERR);
      case (state)
         VAL, NXT: status = 2'b01;
         DONE:     status = 2'b10;
         ERR:      status = 2'b11;
         default:  status = 2'b00;
      endcase
   end

endmodule

// File: tb/tb_lk_accum.sv
// tb_lk_accum: scoreboard bench for lk_accum with a behavioural list walker.
module tb_lk_accum;

   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 8;
   localparam int MAX_NODES = 255;
   localparam int MEM_SZ    = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] head = '0;
   logic [1:0]        mode = '0;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic [DATA_W-1:0] result;
   logic [ADDR_W:0]   nodes;
   logic              busy, done, ovf, loop_err;
   logic [1:0]        status;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   logic [DATA_W-1:0] mem [MEM_SZ];

   typedef struct {
      logic [DATA_W-1:0] result;
      logic [ADDR_W:0]   nodes;
      logic              ovf;
      logic              err;
      int                lat;
      int                t0;
   } exp_t;

   exp_t              exp_q[$];
   logic [ADDR_W-1:0] addr_q[$];
   exp_t              mon_e;
   logic              fin_prev = 1'b0;

   lk_accum #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_NODES(MAX_NODES)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .head(head), .mode(mode),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .result(result), .nodes(nodes), .busy(busy), .done(done), .ovf(ovf),
      .loop_err(loop_err), .status(status)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous memory: data appears the cycle after the read strobe.
   always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Reference walk: follows the list in the bench memory with plain arithmetic.
   task automatic predict(input logic [ADDR_W-1:0] h, input logic [1:0] md);
      exp_t e;
      longint unsigned acc;
      int n, p, nx;
      bit ov, er;
      acc = 0; n = 0; ov = 0; er = 0; p = int'(h);
      while (p != 0) begin
         addr_q.push_back(ADDR_W'(p));
         addr_q.push_back(ADDR_W'((p + 1) % MEM_SZ));
         case (md)
            2'd0: begin
               acc = acc + longint'(mem[p]);
               if (acc >= 64'h1_0000_0000) begin
                  ov = 1;
                  acc = acc - 64'h1_0000_0000;
               end
            end
            2'd1: if (longint'(mem[p]) > acc) acc = longint'(mem[p]);
            2'd3: acc = acc ^ longint'(mem[p]);
            default: ;
         endcase
         n++;
         if (md == 2'd2) acc = longint'(n);
         nx = int'(mem[(p + 1) % MEM_SZ] % MEM_SZ);
         if (nx == 0) p = 0;
         else if (n == MAX_NODES) begin er = 1; p = 0; end
         else p = nx;
      end
      e.result = acc[DATA_W-1:0];
      e.nodes  = n[ADDR_W:0];
      e.ovf    = ov;
      e.err    = er;
      e.lat    = (n == 0) ? 1 : 2 * n + 1;
      e.t0     = cyc;
      exp_q.push_back(e);
   endtask

   task automatic applyStimulus(input logic [ADDR_W-1:0] h, input logic [1:0] md);
      @(posedge clk); #1;
      predict(h, md);
      start = 1'b1; head = h; mode = md;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic pulseStart(input logic [ADDR_W-1:0] h, input logic [1:0] md);
      @(posedge clk); #1;
      start = 1'b1; head = h; mode = md;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic waitDone();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 2000) begin
         @(posedge clk);
         k++;
      end
      if (exp_q.size() != 0) begin
         tests++; fails++;
         $display("[TB] FAIL completion_timeout: %0d results still pending, expected 0", exp_q.size());
         exp_q.delete();
         addr_q.delete();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Monitor: checks every issued read address and every completion.
   always @(negedge clk) begin
      if (mem_rd) begin
         if (addr_q.size() == 0) begin
            tests++; fails++;
            $display("[TB] FAIL mem_rd_unexpected: read at 0x%0h, expected no read", mem_addr);
         end else begin
            checkOutput("mem_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
         end
      end
      if ((done || loop_err) && !fin_prev) begin
         if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("[TB] FAIL completion_unexpected: done=%0b loop_err=%0b, expected none", done, loop_err);
         end else begin
            mon_e = exp_q.pop_front();
            checkOutput("result", 64'(result), 64'(mon_e.result));
            checkOutput("nodes", 64'(nodes), 64'(mon_e.nodes));
            checkOutput("ovf", 64'(ovf), 64'(mon_e.ovf));
            checkOutput("done", 64'(done), 64'(!mon_e.err));
            checkOutput("loop_err", 64'(loop_err), 64'(mon_e.err));
            checkOutput("status", 64'(status), mon_e.err ? 64'd3 : 64'd2);
            checkOutput("busy_end", 64'(busy), 64'd0);
            checkOutput("latency", 64'(cyc - mon_e.t0), 64'(mon_e.lat));
            checkOutput("reads_left", 64'(addr_q.size()), 64'd0);
         end
      end
      fin_prev = done || loop_err;
   end

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_result"}, 64'(result), 64'd0);
      checkOutput({tag, "_nodes"}, 64'(nodes), 64'd0);
      checkOutput({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
      checkOutput({tag, "_mem_rd"}, 64'(mem_rd), 64'd0);
      checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
      checkOutput({tag, "_done"}, 64'(done), 64'd0);
      checkOutput({tag, "_ovf"}, 64'(ovf), 64'd0);
      checkOutput({tag, "_loop_err"}, 64'(loop_err), 64'd0);
      checkOutput({tag, "_status"}, 64'(status), 64'd0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [ADDR_W-1:0] slots[$];
      bit                used [MEM_SZ];
      int                n;
      logic [ADDR_W-1:0] s;

      for (int i = 0; i < MEM_SZ; i++) mem[i] = '0;
      // Fixed list 0x10 -> 0x20 -> 0x30 with values 5, 7, 9.
      mem[8'h10] = 32'd5; mem[8'h11] = 32'h0000_0020;
      mem[8'h20] = 32'd7; mem[8'h21] = 32'hABCD_0030;
      mem[8'h30] = 32'd9; mem[8'h31] = 32'h5500_0000;
      // Overflow pair.
      mem[8'h50] = 32'hFFFF_FFFF; mem[8'h51] = 32'h0000_0060;
      mem[8'h60] = 32'h0000_0002; mem[8'h61] = 32'h0000_0000;
      // Self loop.
      mem[8'h40] = 32'h0200_0000; mem[8'h41] = 32'h0000_0040;
      // Node at the top of memory whose next word wraps to address 0.
      mem[8'hFF] = 32'h0000_1234; mem[8'h00] = 32'h0000_0030;

      repeat (3) @(posedge clk);
      #1;
      checkResetValues("reset");
      rst_n = 1'b1;

      // Empty list: done one cycle later, no read.
      applyStimulus(8'h00, 2'd0);
      waitDone();

      // The fixed list in every mode.
      applyStimulus(8'h10, 2'd0);
      waitDone();
      checkOutput("sum_21", 64'(result), 64'd21);
      applyStimulus(8'h10, 2'd1);
      waitDone();
      checkOutput("max_9", 64'(result), 64'd9);
      applyStimulus(8'h10, 2'd2);
      waitDone();
      checkOutput("count_3", 64'(result), 64'd3);
      applyStimulus(8'h10, 2'd3);
      waitDone();
      checkOutput("xor_0b", 64'(result), 64'h0B);

      // Carry out of the sum.
      applyStimulus(8'h50, 2'd0);
      waitDone();
      checkOutput("ovf_result", 64'(result), 64'd1);
      checkOutput("ovf_flag", 64'(ovf), 64'd1);

      // Pointer wrap at the top of memory.
      applyStimulus(8'hFF, 2'd0);
      waitDone();

      // Starts while busy must be ignored.
      applyStimulus(8'h10, 2'd0);
      pulseStart(8'h40, 2'd3);
      pulseStart(8'h50, 2'd1);
      waitDone();
      checkOutput("busy_start_result", 64'(result), 64'd21);

      // Runaway list.
      applyStimulus(8'h40, 2'd0);
      waitDone();
      checkOutput("loop_nodes", 64'(nodes), 64'd255);

      // Reset during the NXT cycle of node 2.
      applyStimulus(8'h10, 2'd0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("pre_reset_busy", 64'(busy), 64'd1);
      checkOutput("pre_reset_nodes", 64'(nodes), 64'd1);
      rst_n = 1'b0;
      exp_q.delete();
      addr_q.delete();
      #1;
      checkResetValues("midwalk_reset");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(8'h10, 2'd0);
      waitDone();
      checkOutput("post_reset_sum", 64'(result), 64'd21);

      // Random lists in the upper half of memory.
      for (int t = 0; t < 20; t++) begin
         for (int i = 0; i < MEM_SZ; i++) used[i] = 1'b0;
         slots.delete();
         n = $urandom_range(1, 6);
         while (slots.size() < n) begin
            s = ADDR_W'(8'h80 + 2 * $urandom_range(0, 62));
            if (!used[s]) begin
               used[s] = 1'b1;
               slots.push_back(s);
            end
         end
         for (int i = 0; i < n; i++) begin
            mem[slots[i]] = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - $urandom_range(0, 15)) : $urandom;
            if (i == n - 1) mem[slots[i] + 1] = $urandom & 32'hFFFF_FF00;
            else            mem[slots[i] + 1] = ($urandom & 32'hFFFF_FF00) | 32'(slots[i + 1]);
         end
         applyStimulus(slots[0], 2'($urandom_range(0, 3)));
         waitDone();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
